// File: rtl/bsg_rr_encode_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : bsg_rr_encode_arb_pkg
// Purpose  : Shared types and helpers for the round-robin encoded arbiter.
//            - state_e        : grant register occupancy (eEmpty / eFull)
//            - lg_num_in_f()  : width of a binary requester index
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bsg_rr_encode_arb_pkg;

   typedef enum logic [0:0] {
      eEmpty = 1'b0,
      eFull  = 1'b1
   } state_e;

   // Index width for n requesters.
   function automatic int lg_num_in_f(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_rr_scan.sv
//------------------------------------------------------------------------------
// Module   : bsg_rr_scan
// Purpose  : Combinational wrap-around priority scan. Returns the first set
//            request at or after index 'start', wrapping modulo num_in_p.
// Ports    : reqs  [num_in_p-1:0]  in   request vector
//            start [lg_num_in-1:0] in   first index to consider
//            found                 out  at least one request is set
//            index [lg_num_in-1:0] out  winning index (valid when found=1)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bsg_rr_scan
   import bsg_rr_encode_arb_pkg::*;
#(
   parameter  int num_in_p  = 16,
   localparam int lg_num_in = lg_num_in_f(num_in_p)
)(
   input  logic [num_in_p-1:0]  reqs,
   input  logic [lg_num_in-1:0] start,
   output logic                 found,
   output logic [lg_num_in-1:0] index
);

   logic [2*num_in_p-1:0] doubled;
   logic [num_in_p-1:0]   rotated;
   logic [lg_num_in-1:0]  offset;

   // Rotate so that bit 'start' lands at position 0.
   assign doubled = {reqs, reqs} >> start;
   assign rotated = doubled[num_in_p-1:0];

   // Lowest set bit of the rotated vector; scanning downward lets the
   // lowest index overwrite earlier hits.
   always_comb begin
      offset = '0;
      for (int k = num_in_p - 1; k >= 0; k--) begin
         if (rotated[k]) begin
            offset = lg_num_in'(k);
         end
      end
   end

   assign found = |reqs;
   // num_in_p is a power of two, so the natural wrap of the adder is the modulo.
   assign index = offset + start;

endmodule

`default_nettype wire

// File: rtl/bsg_rr_encode_arb.sv
//------------------------------------------------------------------------------
// Module   : bsg_rr_encode_arb
// Purpose  : Round-robin arbiter producing a registered binary grant id with a
//            valid/yumi handshake. Search resumes after the last accepted id.
// Ports    : clk_i    in   clock
//            reset_i  in   asynchronous active-high reset
//            reqs_i   in   [num_in_p-1:0] request vector
//            v_o      out  grant register holds a valid id
//            id_o     out  [lg_num_in-1:0] granted requester index
//            yumi_i   in   consumer accepts id_o (legal only when v_o=1)
//            lock_i   in   keep the same requester next (BSG_RR_ENC_LOCK_EN only)
// Config   : BSG_RR_ENC_LOCK_EN - adds lock_i for multi-beat grants
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bsg_rr_encode_arb
   import bsg_rr_encode_arb_pkg::*;
#(
   parameter  int num_in_p  = 16,
   localparam int lg_num_in = lg_num_in_f(num_in_p)
)(
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [num_in_p-1:0]  reqs_i,
   output logic                 v_o,
   output logic [lg_num_in-1:0] id_o,
`ifdef BSG_RR_ENC_LOCK_EN
   input  logic                 lock_i,
`endif
   input  logic                 yumi_i
);

   localparam logic [lg_num_in-1:0] one_lp = lg_num_in'(1);

   state_e               state_r, state_n;
   logic [lg_num_in-1:0] id_r;
   logic [lg_num_in-1:0] last_r;
   logic [lg_num_in-1:0] last_n;
   logic [lg_num_in-1:0] scan_start;
   logic                 scan_found;
   logic [lg_num_in-1:0] scan_index;
   logic                 accept;
   logic                 load;

   // yumi while empty is ignored.
   assign accept = (state_r == eFull) && yumi_i;

   // Pointer value after this cycle's acceptance. With lock, stepping back
   // one makes the current holder the first candidate of the next scan.
`ifdef BSG_RR_ENC_LOCK_EN
   assign last_n = lock_i ? (id_r - one_lp) : id_r;
`else
   assign last_n = id_r;
`endif

   // Scan from the pointer as updated by this cycle's yumi, not the stale one.
   assign scan_start = accept ? (last_n + one_lp) : (last_r + one_lp);

   bsg_rr_scan #(
      .num_in_p (num_in_p)
   ) u_scan (
      .reqs  (reqs_i),
      .start (scan_start),
      .found (scan_found),
      .index (scan_index)
   );

   always_comb begin
      state_n = state_r;
      load    = 1'b0;
      case (state_r)
         eEmpty: begin
            load    = 1'b1;
            state_n = scan_found ? eFull : eEmpty;
         end
         eFull: begin
            if (yumi_i) begin
               load    = 1'b1;
               state_n = scan_found ? eFull : eEmpty;
            end
         end
         default: begin
            state_n = eEmpty;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r <= eEmpty;
         id_r    <= '0;
         last_r  <= '1;
      end else begin
         state_r <= state_n;
         if (load && scan_found) begin
            id_r <= scan_index;
         end
         if (accept) begin
            last_r <= last_n;
         end
      end
   end

   assign v_o  = (state_r == eFull);
   assign id_o = id_r;

`ifndef SYNTHESIS
   yumi_requires_valid: assert property (@(posedge clk_i) disable iff (reset_i)
      !(yumi_i && !v_o))
      else $error("bsg_rr_encode_arb: yumi_i asserted while v_o=0");
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_rr_encode_arb.sv
//------------------------------------------------------------------------------
// Module   : tb_bsg_rr_encode_arb
// Purpose  : Self-checking bench for bsg_rr_encode_arb (table vectors, corner
//            sequences, randomized traffic against a round-robin model).
// Config   : BSG_RR_ENC_LOCK_EN - also exercises lock_i
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bsg_rr_encode_arb;

   localparam int N  = 16;
   localparam int LG = 4;

   logic          clk_i;
   logic          reset_i;
   logic [N-1:0]  reqs_i;
   logic          v_o;
   logic [LG-1:0] id_o;
   logic          yumi_i;
   logic          lock_i;

   int checks;
   int errors;

   // Reference model state: occupancy, held id, last accepted id.
   int m_v;
   int m_id;
   int m_last;

   typedef struct {
      logic [N-1:0]  reqs;
      logic          yumi;
      logic          exp_v;
      logic [LG-1:0] exp_id;
      string         name;
   } vec_t;

   vec_t vecs[$];

   bsg_rr_encode_arb #(
      .num_in_p (N)
   ) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .reqs_i  (reqs_i),
      .v_o     (v_o),
      .id_o    (id_o),
`ifdef BSG_RR_ENC_LOCK_EN
      .lock_i  (lock_i),
`endif
      .yumi_i  (yumi_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_v    = 0;
      m_id   = 0;
      m_last = N - 1;
   endtask

   // Round-robin rule: after an accept, the pointer moves to the accepted id
   // (or one before it when locked); a load picks the first requester found
   // walking forward from pointer+1 around the ring.
   task automatic model_step(input logic [N-1:0] rq, input logic y, input logic lk);
      logic lock_eff;
      int   found;
`ifdef BSG_RR_ENC_LOCK_EN
      lock_eff = lk;
`else
      lock_eff = 1'b0;
`endif
      if (m_v == 1 && y) begin
         m_last = lock_eff ? (m_id + N - 1) % N : m_id;
      end
      if (m_v == 0 || y) begin
         found = 0;
         for (int k = 1; k <= N; k++) begin
            if (found == 0 && rq[(m_last + k) % N]) begin
               found = 1;
               m_id  = (m_last + k) % N;
            end
         end
         m_v = found;
      end
   endtask

   // Drive one cycle of inputs, advance the model, then compare just after the edge.
   task automatic cycle(input logic [N-1:0] rq, input logic y, input logic lk, input string nm);
      reqs_i = rq;
      yumi_i = y;
      lock_i = lk;
      @(posedge clk_i);
      model_step(rq, y, lk);
      #1;
      check({nm, " model v"}, int'(v_o), m_v);
      if (m_v == 1) begin
         check({nm, " model id"}, int'(id_o), m_id);
      end
   endtask

   task automatic add_vec(input logic [N-1:0] rq, input logic y, input logic ev,
                          input int eid, input string nm);
      vec_t v;
      v.reqs   = rq;
      v.yumi   = y;
      v.exp_v  = ev;
      v.exp_id = LG'(eid);
      v.name   = nm;
      vecs.push_back(v);
   endtask

   initial begin
      logic [N-1:0] rq;
      logic         y;
      logic         lk;

      checks  = 0;
      errors  = 0;
      reset_i = 1'b1;
      reqs_i  = '0;
      yumi_i  = 1'b0;
      lock_i  = 1'b0;
      model_reset();

      // Directed vectors, starting from a freshly reset arbiter.
      add_vec(16'hFFFF, 1'b0, 1'b1, 0, "all_req_first");
      for (int k = 1; k <= 16; k++) begin
         add_vec(16'hFFFF, 1'b1, 1'b1, k % 16, "all_req_rotate");
      end
      add_vec(16'h8001, 1'b1, 1'b1, 15, "ends_alt");
      add_vec(16'h8001, 1'b1, 1'b1, 0,  "ends_alt");
      add_vec(16'h8001, 1'b1, 1'b1, 15, "ends_alt");
      add_vec(16'h8001, 1'b1, 1'b1, 0,  "ends_alt");
      add_vec(16'h0001, 1'b1, 1'b1, 0,  "single_regrant");
      add_vec(16'h0001, 1'b1, 1'b1, 0,  "single_regrant");
      add_vec(16'h0020, 1'b1, 1'b1, 5,  "grant5");
      for (int k = 0; k < 4; k++) begin
         add_vec(16'h0100, 1'b0, 1'b1, 5, "hold5");
      end
      add_vec(16'h0100, 1'b1, 1'b1, 8, "after_hold");
      add_vec(16'h0000, 1'b1, 1'b0, 0, "drain");
      add_vec(16'h0000, 1'b0, 1'b0, 0, "stay_empty");

      // Reset state held for several cycles with no requests.
      for (int k = 0; k < 5; k++) begin
         @(posedge clk_i);
         #1;
         check("reset v", int'(v_o), 0);
         check("reset id", int'(id_o), 0);
      end
      reset_i = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i].reqs, vecs[i].yumi, 1'b0, vecs[i].name);
         check({vecs[i].name, " v"}, int'(v_o), int'(vecs[i].exp_v));
         if (vecs[i].exp_v) begin
            check({vecs[i].name, " id"}, int'(id_o), int'(vecs[i].exp_id));
         end
      end

      // Asynchronous reset while FULL: v_o must drop before the next edge.
      cycle(16'h0400, 1'b0, 1'b0, "prefill");
      check("prefill v", int'(v_o), 1);
      #2;
      reset_i = 1'b1;
      #1;
      check("async_reset v", int'(v_o), 0);
      check("async_reset id", int'(id_o), 0);
      model_reset();
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;

      // After reset the pointer restarts: first search begins at requester 0.
      cycle(16'hFFFF, 1'b0, 1'b0, "post_reset");
      check("post_reset id", int'(id_o), 0);
      cycle(16'h0000, 1'b1, 1'b0, "post_reset_drain");

`ifdef BSG_RR_ENC_LOCK_EN
      cycle(16'h0018, 1'b0, 1'b0, "lock_first");
      check("lock_first id", int'(id_o), 3);
      cycle(16'h0018, 1'b1, 1'b1, "lock1");
      check("lock1 id", int'(id_o), 3);
      cycle(16'h0018, 1'b1, 1'b1, "lock2");
      check("lock2 id", int'(id_o), 3);
      cycle(16'h0018, 1'b1, 1'b0, "unlock");
      check("unlock id", int'(id_o), 4);
      cycle(16'h0000, 1'b1, 1'b0, "lock_drain");
`endif

      // Randomized traffic; yumi only offered while the model holds a grant.
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0:       rq = '0;
            1:       rq = N'(1) << $urandom_range(0, N - 1);
            2:       rq = N'($urandom) & N'($urandom);
            default: rq = N'($urandom);
         endcase
         y  = (m_v == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
         lk = ($urandom_range(0, 3) == 0);
         cycle(rq, y, lk, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
